// File: rtl/any1_pkg.sv
// Shared types and constants for the any1 fetch/align path.
package any1_pkg;

  localparam int AWID = 32;
  localparam logic [63:0] NOP_INSN = 64'h0000_0000_0000_003F;

  localparam int ALIGN_QDEPTH = 2;
  localparam logic [5:0] ALIGN_SPLIT_OFS = 6'd56;

  typedef enum logic {
    ALIGN_IDLE,
    ALIGN_SPLIT
  } AlignState;

  typedef struct packed {
    logic [3:0]      stream;
    logic [7:0]      rid;
    logic [AWID-1:0] ip;
    logic [AWID-1:0] pip;
    logic            predict_taken;
    logic [511:0]    cacheline;
  } sInstAlignIn;

  typedef struct packed {
    logic [3:0]      stream;
    logic [7:0]      rid;
    logic [AWID-1:0] ip;
    logic [AWID-1:0] pip;
    logic            predict_taken;
    logic [63:0]     ir;
  } sInstAlignOut;

  // Bytes off..off+7 of a line, byte off landing in bits [7:0]; bytes past
  // the end of the line read as zero.
  function automatic logic [63:0] extract_bytes(input logic [511:0] line, input logic [5:0] off);
    return 64'(line >> {off, 3'b000});
  endfunction

endpackage

// File: rtl/any1_align_q.sv
// Two-entry FIFO of aligned instruction words with flush and occupancy count.
module any1_align_q
  import any1_pkg::*;
#(
  parameter int DEPTH = ALIGN_QDEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  sInstAlignOut push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output sInstAlignOut head_o,
  output logic [1:0]   count_o
);

  sInstAlignOut mem_reg [DEPTH];
  logic         wptr_reg;
  logic         rptr_reg;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;

  always_comb begin
    count_next = count_reg;
    case ({push_i, pop_i})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset; the head is masked by valid_o downstream.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_i) begin
      mem_reg[wptr_reg] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_reg  <= 1'b0;
      rptr_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (push_i) wptr_reg <= ~wptr_reg;
      if (pop_i)  rptr_reg <= ~rptr_reg;
      count_reg <= count_next;
    end
  end

  assign valid_o = (count_reg != 2'd0);
  assign head_o  = mem_reg[rptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/any1_inst_align.sv
// Extracts the 64-bit instruction word at ip from a fetched cacheline, stitching
// words that straddle two consecutive lines, and queues results for decode.
module any1_inst_align
  import any1_pkg::*;
#(
  parameter int QDEPTH     = ALIGN_QDEPTH,
  parameter int LINE_BYTES = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  sInstAlignIn  in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output sInstAlignOut out_o,
  input  logic         flush_i,
  output logic         seq_err_o
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int HI_W  = AWID - OFF_W;

  AlignState        state_reg, state_next;
  sInstAlignOut     saved_reg, saved_next;
  logic [OFF_W-1:0] saved_off_reg, saved_off_next;
  logic             seq_err_reg, seq_err_next;

  logic [1:0]       count;
  logic             accept;
  logic             pop;
  logic             push;
  logic             cont_ok;
  logic [OFF_W-1:0] off;
  logic [9:0]       cont_shift;
  sInstAlignOut     fresh_entry;
  sInstAlignOut     push_data;
  sInstAlignOut     head;

  assign off        = in_i.ip[OFF_W-1:0];
  assign in_ready_o = (count < 2'(QDEPTH));
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;

  // A continuation must come from the very next line of the same stream.
  assign cont_ok = (in_i.ip[AWID-1:OFF_W] == saved_reg.ip[AWID-1:OFF_W] + HI_W'(1))
                && (in_i.stream == saved_reg.stream);

  // The saved tail holds (LINE_BYTES - saved_off) bytes; the new line fills above it.
  assign cont_shift = {7'(LINE_BYTES) - {1'b0, saved_off_reg}, 3'b000};

  always_comb begin
    fresh_entry               = '0;
    fresh_entry.stream        = in_i.stream;
    fresh_entry.rid           = in_i.rid;
    fresh_entry.ip            = in_i.ip;
    fresh_entry.pip           = in_i.pip;
    fresh_entry.predict_taken = in_i.predict_taken;
    fresh_entry.ir            = extract_bytes(in_i.cacheline, off);
  end

  always_comb begin
    state_next     = state_reg;
    saved_next     = saved_reg;
    saved_off_next = saved_off_reg;
    seq_err_next   = 1'b0;
    push           = 1'b0;
    push_data      = fresh_entry;
    if (accept) begin
      if (state_reg == ALIGN_SPLIT && cont_ok) begin
        push         = 1'b1;
        push_data    = saved_reg;
        push_data.ir = saved_reg.ir | (in_i.cacheline[63:0] << cont_shift);
        state_next   = ALIGN_IDLE;
      end else begin
        seq_err_next = (state_reg == ALIGN_SPLIT);
        if (off > ALIGN_SPLIT_OFS) begin
          state_next     = ALIGN_SPLIT;
          saved_next     = fresh_entry;
          saved_off_next = off;
        end else begin
          push       = 1'b1;
          state_next = ALIGN_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_reg     <= ALIGN_IDLE;
      saved_reg     <= '0;
      saved_off_reg <= '0;
      seq_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      saved_reg     <= saved_next;
      saved_off_reg <= saved_off_next;
      seq_err_reg   <= seq_err_next;
    end
  end

  any1_align_q #(
    .DEPTH(QDEPTH)
  ) u_q (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .valid_o    (out_valid_o),
    .head_o     (head),
    .count_o    (count)
  );

  always_comb begin
    out_o    = '0;
    out_o.ir = NOP_INSN;
    if (out_valid_o) out_o = head;
  end

  assign seq_err_o = seq_err_reg;

endmodule

// File: tb/tb_any1_inst_align.sv
// Bench for any1_inst_align: directed scenarios plus randomized traffic checked
// every cycle against a byte-level queue model.
module tb_any1_inst_align;
  import any1_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  sInstAlignIn  in_beat;
  logic         out_valid;
  logic         out_ready;
  sInstAlignOut out_word;
  logic         flush;
  logic         seq_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  any1_inst_align #(
    .QDEPTH    (2),
    .LINE_BYTES(64)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_i       (in_beat),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_o      (out_word),
    .flush_i    (flush),
    .seq_err_o  (seq_err)
  );

  // Reference model: list of words waiting for decode, plus an optional pending first half.
  sInstAlignOut mq[$];
  bit           pend = 1'b0;
  sInstAlignOut pend_word;
  logic [511:0] pend_line;
  int           pend_off;
  bit           exp_err = 1'b0;

  function automatic logic [63:0] gather(input logic [511:0] l1, input logic [511:0] l2, input int off);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = off + k;
      if (idx < 64) r[k*8 +: 8] = l1[idx*8 +: 8];
      else          r[k*8 +: 8] = l2[(idx-64)*8 +: 8];
    end
    return r;
  endfunction

  task automatic model_accept();
    int off;
    sInstAlignOut w;
    off = int'(in_beat.ip[5:0]);
    if (pend && in_beat.ip[31:6] == pend_word.ip[31:6] + 26'd1 && in_beat.stream == pend_word.stream) begin
      w = pend_word;
      w.ir = gather(pend_line, in_beat.cacheline, pend_off);
      mq.push_back(w);
      pend = 1'b0;
      return;
    end
    if (pend) exp_err = 1'b1;
    pend = 1'b0;
    w = '0;
    w.stream        = in_beat.stream;
    w.rid           = in_beat.rid;
    w.ip            = in_beat.ip;
    w.pip           = in_beat.pip;
    w.predict_taken = in_beat.predict_taken;
    if (off + 8 > 64) begin
      pend      = 1'b1;
      pend_word = w;
      pend_line = in_beat.cacheline;
      pend_off  = off;
    end else begin
      w.ir = gather(in_beat.cacheline, 512'd0, off);
      mq.push_back(w);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    bit popd;
    acc  = in_valid && (mq.size() < 2);
    popd = out_ready && (mq.size() > 0);
    exp_err = 1'b0;
    if (!rst_n || flush) begin
      mq.delete();
      pend = 1'b0;
    end else begin
      if (popd) void'(mq.pop_front());
      if (acc) model_accept();
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sInstAlignOut want;
    chk1("in_ready", in_ready, mq.size() < 2);
    chk1("out_valid", out_valid, mq.size() > 0);
    chk1("seq_err", seq_err, exp_err);
    want    = '0;
    want.ir = NOP_INSN;
    if (mq.size() > 0) want = mq[0];
    total++;
    if (out_word !== want) begin
      bad++;
      $display("FAIL out_o actual=%h required=%h", out_word, want);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic put(input logic v, input logic [31:0] ip, input logic [3:0] st, input logic [511:0] line);
    in_valid                = v;
    in_beat.ip              = ip;
    in_beat.stream          = st;
    in_beat.cacheline       = line;
    in_beat.rid             = 8'($urandom);
    in_beat.pip             = $urandom;
    in_beat.predict_taken   = 1'($urandom);
  endtask

  initial begin
    logic [511:0] l1;
    logic [511:0] l2;
    logic [7:0]   r0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_beat = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk64("rst_ir_nop", out_word.ir, NOP_INSN);

    // Aligned word inside one line
    l1 = rand_line();
    for (int k = 0; k < 8; k++) l1[(8+k)*8 +: 8] = 8'(8'h11 * (k + 1));
    put(1'b1, 32'hFFFD0008, 4'd1, l1);
    r0 = in_beat.rid;
    step(); in_valid = 1'b0;
    chk1("t31_valid", out_valid, 1'b1);
    chk64("t31_ir", out_word.ir, 64'h8877665544332211);
    chk64("t31_ip", 64'(out_word.ip), 64'hFFFD0008);
    chk64("t31_rid", 64'(out_word.rid), 64'(r0));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Word straddling two consecutive lines
    l1 = rand_line(); l2 = rand_line();
    put(1'b1, 32'h0000103C, 4'd2, l1); step();
    chk1("t32_none", out_valid, 1'b0);
    put(1'b1, 32'h00001040, 4'd2, l2); step(); in_valid = 1'b0;
    chk1("t32_valid", out_valid, 1'b1);
    chk64("t32_ir", out_word.ir, {l2[31:0], l1[511:480]});
    chk64("t32_ip", 64'(out_word.ip), 64'h103C);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Back-pressure: third beat held until space opens
    put(1'b1, 32'h2000, 4'd0, rand_line()); step();
    put(1'b1, 32'h2108, 4'd0, rand_line()); step();
    put(1'b1, 32'h2210, 4'd0, rand_line()); step();
    chk1("t33_full", in_ready, 1'b0);
    chk64("t33_head0", 64'(out_word.ip), 64'h2000);
    out_ready = 1'b1; step();
    chk64("t33_head1", 64'(out_word.ip), 64'h2108);
    step(); in_valid = 1'b0;
    chk64("t33_head2", 64'(out_word.ip), 64'h2210);
    step(); out_ready = 1'b0;
    chk1("t33_empty", out_valid, 1'b0);

    // Broken continuation
    l1 = rand_line(); l2 = rand_line();
    put(1'b1, 32'h307C, 4'd3, l1); step();
    put(1'b1, 32'h3200, 4'd3, l2); step(); in_valid = 1'b0;
    chk1("t34_err", seq_err, 1'b1);
    chk1("t34_valid", out_valid, 1'b1);
    chk64("t34_ir", out_word.ir, l2[63:0]);
    chk64("t34_ip", 64'(out_word.ip), 64'h3200);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk1("t34_err_clr", seq_err, 1'b0);

    // Flush with an entry queued and a split pending
    put(1'b1, 32'h4000, 4'd1, rand_line()); step();
    put(1'b1, 32'h40BC, 4'd1, rand_line()); step();
    put(1'b1, 32'h40C0, 4'd1, rand_line()); flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    chk1("t35_valid", out_valid, 1'b0);
    chk1("t35_ready", in_ready, 1'b1);
    chk1("t35_err", seq_err, 1'b0);
    l2 = rand_line();
    put(1'b1, 32'h40C0, 4'd1, l2); step(); in_valid = 1'b0;
    chk64("t35_fresh_ir", out_word.ir, l2[63:0]);
    chk1("t35_fresh_err", seq_err, 1'b0);
    put(1'b1, 32'h4100, 4'd1, rand_line()); step(); in_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk1("t35_full_flush", out_valid, 1'b0);

    // Reset mid-split
    l1 = rand_line(); l2 = rand_line();
    put(1'b1, 32'h50FC, 4'd2, l1); step();
    put(1'b1, 32'h5100, 4'd2, l2); out_ready = 1'b1; rst_n = 1'b0; step();
    rst_n = 1'b1; in_valid = 1'b0;
    chk1("t36_valid", out_valid, 1'b0);
    chk64("t36_ir", out_word.ir, NOP_INSN);
    chk1("t36_err", seq_err, 1'b0);
    chk1("t36_ready", in_ready, 1'b1);
    put(1'b1, 32'h5100, 4'd2, l2); step(); in_valid = 1'b0;
    chk64("t36_fresh_ir", out_word.ir, l2[63:0]);
    step(); out_ready = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ip;
      logic [3:0]  st;
      logic [5:0]  off;
      rst_n     = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      off = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(57, 63)) : 6'($urandom);
      if (pend && $urandom_range(0, 9) < 7) begin
        ip = {pend_word.ip[31:6] + 26'd1, off};
        st = ($urandom_range(0, 4) != 0) ? pend_word.stream : 4'($urandom_range(0, 1));
      end else begin
        ip = {26'($urandom_range(0, 15)), off};
        st = 4'($urandom_range(0, 1));
      end
      put(($urandom_range(0, 3) != 0), ip, st, rand_line());
      step();
    end

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/any1_inst_align.md
ANY1_INST_ALIGN -- requirements
Module: any1_inst_align

Interface
REQ-001 Parameter: QDEPTH, 2, output queue depth in entries (fixed at 2).
REQ-002 Parameter: LINE_BYTES, 64, fetch cacheline size in bytes (matches 512-bit sInstAlignIn.cacheline).
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  upstream beat valid.
REQ-006 in_ready_o  output  1  block can accept a beat this cycle.
REQ-007 in_i  input  sInstAlignIn  Stream, rid, ip, pip, predict_taken, 512-bit cacheline.
REQ-008 out_valid_o  output  1  queue head valid.
REQ-009 out_ready_i  input  1  decode stage accepts head.
REQ-010 out_o  output  sInstAlignOut  aligned 64-bit ir plus carried fields.
REQ-011 flush_i  input  1  discard all buffered and partial state.
REQ-012 seq_err_o  output  1  one-cycle pulse: split continuation beat mismatch.

Function
REQ-013 Beat accepted when in_valid_i && in_ready_o; out entry popped when out_valid_o && out_ready_i.
REQ-014 in_ready_o = (count < QDEPTH), decoded from registered count only; no combinational path from out_ready_i.
REQ-015 Offset off = ip[5:0]; ir = cacheline bytes off..off+7, byte off in ir[7:0] (little-endian).
REQ-016 off <= 56: non-split; entry written to queue tail on accept; out_valid_o visible next cycle (latency 1).
REQ-017 off > 56: split; state IDLE -> SPLIT; save low (64-off) bytes from cacheline[511:off*8] plus Stream, rid, ip, pip, predict_taken; nothing enqueued.
REQ-018 In SPLIT, next accepted beat with ip[31:6] == saved ip[31:6]+1 and equal Stream: ir = {beat cacheline low (off-56) bytes, saved bytes}; carried fields from saved (first) beat; enqueue; SPLIT -> IDLE.
REQ-019 In SPLIT, accepted beat failing REQ-018 check: seq_err_o pulses next cycle, partial discarded, beat processed as fresh per REQ-016/017.
REQ-020 In SPLIT, in_ready_o additionally requires count < QDEPTH (continuation always enqueues).
REQ-021 Simultaneous push and pop: count unchanged; push into full queue impossible by REQ-014.
REQ-022 out_o driven from queue head; when out_valid_o low, out_o.ir = NOP_INSN, other fields 0.
REQ-023 Read/write pointers 1 bit each, wrap modulo QDEPTH; count 0..2.
REQ-024 flush_i: next cycle count=0, pointers=0, state=IDLE, out_valid_o=0; concurrent accept and pop ignored; seq_err_o not asserted.
REQ-025 Beat with in_valid_i low or in_ready_o low: no state change.

Reset
REQ-026 rst_ni low at clock edge: state=IDLE, count=0, pointers=0, saved partial cleared, seq_err_o=0, out_valid_o=0, out_o per REQ-022.
REQ-027 Reset mid-SPLIT or with full queue: all content discarded, no pop/push that cycle; in_ready_o=1 first cycle after reset release.
REQ-028 Reset has priority over flush_i, flush_i over push/pop.

Structure
REQ-029 any1_pkg gains: AlignState enum (ALIGN_IDLE, ALIGN_SPLIT), ALIGN_QDEPTH=2, ALIGN_SPLIT_OFS=6'd56; reuses sInstAlignIn, sInstAlignOut, NOP_INSN, AWID.
REQ-030 One sub-module: any1_align_q (2-entry sInstAlignOut FIFO, push/pop/flush, count); byte extraction and split FSM stay in any1_inst_align.

Verification
REQ-031 Reset release, one beat ip=32'hFFFD0008, cacheline bytes 8..15 = 11..88 -> next cycle out_valid_o=1, ir=64'h8877665544332211, ip, rid passed unchanged.
REQ-032 Beat ip=...003C (off 60) then ip=...0040 -> no output after first; after second ir = {line2 bytes 0..3, line1 bytes 60..63}, ip=...003C.
REQ-033 out_ready_i=0, three back-to-back beats -> in_ready_o low after two accepted; third held; raise out_ready_i -> order preserved, no loss or duplication.
REQ-034 Split first beat ip=...007C, then ip=...0200 -> seq_err_o one cycle, second beat emitted alone as non-split.
REQ-035 Queue holding 2 entries, state SPLIT, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, count 0, IDLE, in_ready_o=1, no seq_err_o.
REQ-036 rst_ni low for one cycle mid-SPLIT with out_ready_i=1 -> no output emitted, all outputs at reset values next cycle.
